// File: rtl/read_check_master.sv
// read_check_master: Avalon-MM pipelined read master that walks a block of
// word addresses, compares every returned word against a fixed pattern and
// reports the number of mismatches plus the address/data of the first one.
module read_check_master #(
  parameter int          ADDRESSWIDTH    = 25,
  parameter int          DATAWIDTH       = 32,
  parameter int          BYTEENABLEWIDTH = 4,
  parameter int          MAX_PENDING     = 8,
  parameter logic [31:0] PATTERN         = 32'hDEADBEEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ADDRESSWIDTH-1:0]    base_address,
  input  logic [ADDRESSWIDTH-1:0]    length,
  output logic [ADDRESSWIDTH-1:0]    address,
  output logic                       read,
  output logic [BYTEENABLEWIDTH-1:0] byteenable,
  input  logic                       waitrequest,
  input  logic [DATAWIDTH-1:0]       readdata,
  input  logic                       readdatavalid,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                error_count,
  output logic [ADDRESSWIDTH-1:0]    first_error_address,
  output logic [DATAWIDTH-1:0]       first_error_data
);

  localparam logic [3:0]           MAX_P     = 4'(MAX_PENDING);
  localparam logic [DATAWIDTH-1:0] PATTERN_W = DATAWIDTH'(PATTERN);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [ADDRESSWIDTH-1:0] issue_addr;
  logic [ADDRESSWIDTH-1:0] issue_left;
  logic [ADDRESSWIDTH-1:0] check_addr;
  logic [3:0]              pending, pending_nxt;
  logic                    err_flag;
  logic                    start_ok;
  logic                    accept;
  logic                    rsp;
  logic                    mismatch;

  // Run is only (re)started from a quiescent state; starts mid-run are dropped.
  assign start_ok = start && ((state == IDLE) || (state == DONE));
  // Responses only count while a run is active, so strays after reset vanish.
  assign rsp      = readdatavalid && ((state == READ) || (state == DRAIN));
  assign read     = (state == READ) && (pending < MAX_P);
  assign accept   = read && !waitrequest;
  assign mismatch = (readdata != PATTERN_W);

  assign address    = issue_addr;
  assign byteenable = '1;

  // Outstanding-read counter update; a same-cycle accept and response cancel.
  always_comb begin
    pending_nxt = pending;
    if (accept && !rsp) begin
      pending_nxt = pending + 4'd1;
    end else if (rsp && !accept && (pending != 4'd0)) begin
      pending_nxt = pending - 4'd1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        done = (state == DONE);
        if (start) begin
          state_nxt = (length != '0) ? READ : DONE;
        end
      end
      READ: begin
        busy = 1'b1;
        if (accept && (issue_left == ADDRESSWIDTH'(1))) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pending_nxt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command side: issue address and remaining command count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_addr <= '0;
      issue_left <= '0;
      pending    <= 4'd0;
    end else begin
      pending <= pending_nxt;
      if (start_ok) begin
        issue_addr <= base_address;
        issue_left <= length;
      end else if (accept) begin
        issue_addr <= issue_addr + ADDRESSWIDTH'(1);
        issue_left <= issue_left - ADDRESSWIDTH'(1);
      end
    end
  end

  // Response side: track the address of each returning word and log errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      check_addr          <= '0;
      error_count         <= 16'd0;
      first_error_address <= '0;
      first_error_data    <= '0;
      err_flag            <= 1'b0;
    end else if (start_ok) begin
      check_addr          <= base_address;
      error_count         <= 16'd0;
      first_error_address <= '0;
      first_error_data    <= '0;
      err_flag            <= 1'b0;
    end else if (rsp) begin
      check_addr <= check_addr + ADDRESSWIDTH'(1);
      if (mismatch) begin
        if (error_count != 16'hFFFF) begin
          error_count <= error_count + 16'd1;
        end
        if (!err_flag) begin
          first_error_address <= check_addr;
          first_error_data    <= readdata;
          err_flag            <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_read_check_master.sv
// Directed bench for read_check_master with an in-order Avalon read responder.
module tb_read_check_master;

  logic        clk;
  logic        reset;
  logic        start;
  logic [24:0] base_address;
  logic [24:0] length;
  logic [24:0] address;
  logic        read;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        busy;
  logic        done;
  logic [15:0] error_count;
  logic [24:0] first_error_address;
  logic [31:0] first_error_data;

  int tests;
  int fails;

  logic [24:0] q[$];
  logic [24:0] acc_log[$];
  int          max_out;
  logic        rsp_en;
  logic        bad_en;
  logic [24:0] bad_addr;
  logic [31:0] bad_data;
  logic        force_bad;
  logic        s_read;
  logic        s_done;
  logic [24:0] s_addr;

  read_check_master dut (
    .clk                 (clk),
    .reset               (reset),
    .start               (start),
    .base_address        (base_address),
    .length              (length),
    .address             (address),
    .read                (read),
    .byteenable          (byteenable),
    .waitrequest         (waitrequest),
    .readdata            (readdata),
    .readdatavalid       (readdatavalid),
    .busy                (busy),
    .done                (done),
    .error_count         (error_count),
    .first_error_address (first_error_address),
    .first_error_data    (first_error_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] data_for(input logic [24:0] a);
    if (force_bad) return 32'h0BAD0BAD;
    if (bad_en && (a == bad_addr)) return bad_data;
    return 32'hDEADBEEF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, record accepts, drive responses after posedge.
  task automatic tick();
    logic [24:0] a;
    @(negedge clk);
    s_read = read;
    s_done = done;
    s_addr = address;
    if (read && !waitrequest) begin
      acc_log.push_back(address);
      q.push_back(address);
    end
    if (q.size() > max_out) max_out = q.size();
    @(posedge clk);
    #1;
    if (rsp_en && (q.size() != 0)) begin
      a             = q.pop_front();
      readdatavalid = 1'b1;
      readdata      = data_for(a);
    end else begin
      readdatavalid = 1'b0;
      readdata      = '0;
    end
  endtask

  task automatic do_start(input logic [24:0] b, input logic [24:0] l);
    acc_log.delete();
    max_out      = 0;
    start        = 1'b1;
    base_address = b;
    length       = l;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (s_done) begin
        got = 1'b1;
        break;
      end
    end
    check(tag, 64'(got), 64'd1);
  endtask

  initial begin
    tests         = 0;
    fails         = 0;
    reset         = 1'b1;
    start         = 1'b0;
    base_address  = '0;
    length        = '0;
    waitrequest   = 1'b0;
    readdata      = '0;
    readdatavalid = 1'b0;
    rsp_en        = 1'b1;
    bad_en        = 1'b0;
    bad_addr      = '0;
    bad_data      = '0;
    force_bad     = 1'b0;
    max_out       = 0;
    s_read        = 1'b0;
    s_done        = 1'b0;
    s_addr        = '0;

    // Reset state
    #12;
    check("rst_read", 64'(read), 64'd0);
    check("rst_addr", 64'(address), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_errcnt", 64'(error_count), 64'd0);
    check("rst_fea", 64'(first_error_address), 64'd0);
    check("rst_fed", 64'(first_error_data), 64'd0);
    check("byteenable", 64'(byteenable), 64'hF);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Clean 4-word run
    do_start(25'h100, 25'd4);
    check("t1_busy", 64'(busy), 64'd1);
    run_until_done("t1_timeout", 50);
    check("t1_naccept", 64'(acc_log.size()), 64'd4);
    check("t1_addr0", 64'(acc_log[0]), 64'h100);
    check("t1_addr3", 64'(acc_log[3]), 64'h103);
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_end", 64'(busy), 64'd0);
    check("t1_errcnt", 64'(error_count), 64'd0);

    // One corrupted word
    bad_en   = 1'b1;
    bad_addr = 25'd1;
    bad_data = 32'h12345678;
    do_start(25'd0, 25'd3);
    run_until_done("t2_timeout", 50);
    check("t2_errcnt", 64'(error_count), 64'd1);
    check("t2_fea", 64'(first_error_address), 64'd1);
    check("t2_fed", 64'(first_error_data), 64'h12345678);
    bad_en = 1'b0;

    // Zero length: done immediately, results cleared, no reads
    do_start(25'h55, 25'd0);
    tick();
    check("t3_done", 64'(s_done), 64'd1);
    check("t3_noread", 64'(acc_log.size()), 64'd0);
    check("t3_errcnt_clr", 64'(error_count), 64'd0);
    check("t3_fea_clr", 64'(first_error_address), 64'd0);
    check("t3_fed_clr", 64'(first_error_data), 64'd0);

    // Waitrequest stall on first command
    waitrequest = 1'b1;
    do_start(25'h40, 25'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_read_held", 64'(s_read), 64'd1);
      check("t4_addr_held", 64'(s_addr), 64'h40);
    end
    waitrequest = 1'b0;
    run_until_done("t4_timeout", 50);
    check("t4_naccept", 64'(acc_log.size()), 64'd2);
    check("t4_addr0", 64'(acc_log[0]), 64'h40);
    check("t4_addr1", 64'(acc_log[1]), 64'h41);

    // Pending limit with responses withheld
    rsp_en = 1'b0;
    do_start(25'h200, 25'd20);
    for (int i = 0; i < 12; i++) tick();
    check("t5_naccept_cap", 64'(acc_log.size()), 64'd8);
    check("t5_read_low", 64'(s_read), 64'd0);
    check("t5_busy", 64'(busy), 64'd1);
    rsp_en = 1'b1;
    run_until_done("t5_timeout", 200);
    check("t5_naccept", 64'(acc_log.size()), 64'd20);
    check("t5_last_addr", 64'(acc_log[19]), 64'h213);
    check("t5_max_out", 64'(max_out), 64'd8);
    check("t5_errcnt", 64'(error_count), 64'd0);

    // Address wrap
    do_start(25'h1FFFFFF, 25'd2);
    run_until_done("t6_timeout", 50);
    check("t6_addr0", 64'(acc_log[0]), 64'h1FFFFFF);
    check("t6_addr1", 64'(acc_log[1]), 64'h0);

    // Reset mid-run, then stray late responses
    rsp_en = 1'b0;
    do_start(25'h300, 25'd10);
    for (int i = 0; i < 3; i++) tick();
    check("t7_outstanding", 64'(q.size()), 64'd3);
    reset = 1'b1;
    #2;
    check("t7_rst_read", 64'(read), 64'd0);
    check("t7_rst_addr", 64'(address), 64'd0);
    check("t7_rst_busy", 64'(busy), 64'd0);
    check("t7_rst_done", 64'(done), 64'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    rsp_en    = 1'b1;
    force_bad = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t7_late_errcnt", 64'(error_count), 64'd0);
    check("t7_late_fea", 64'(first_error_address), 64'd0);
    check("t7_late_busy", 64'(busy), 64'd0);
    check("t7_late_done", 64'(done), 64'd0);
    check("t7_late_read", 64'(read), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
